// File: rtl/mem_pkg.sv
// Shared constants and state encoding for the instruction/data memory port arbiter.
package mem_pkg;

  localparam logic [1:0] BYTE = 2'h0;
  localparam logic [1:0] HALF = 2'h1;
  localparam logic [1:0] WORD = 2'h2;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_RESP = 2'd1,
    LS_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_port_arbiter_load_extend.sv
// Sign/zero extension of right-justified load data according to RISC-V funct3.
module load_extend
  import mem_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic [2:0]           i_funct3,
  input  logic [WORD_SIZE-1:0] i_raw,
  output logic [WORD_SIZE-1:0] o_data
);

  always_comb begin
    o_data = i_raw;
    case (i_funct3)
      LB:      o_data = {{(WORD_SIZE - 8){i_raw[7]}}, i_raw[7:0]};
      LH:      o_data = {{(WORD_SIZE - 16){i_raw[15]}}, i_raw[15:0]};
      LBU:     o_data = {{(WORD_SIZE - 8){1'b0}}, i_raw[7:0]};
      LHU:     o_data = {{(WORD_SIZE - 16){1'b0}}, i_raw[15:0]};
      default: o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port I/D memory between fetch and load/store, LS priority with an
// IF starvation guard; responses are registered and arrive exactly one cycle after grant.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [WORD_SIZE-1:0] if_addr,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [WORD_SIZE-1:0] if_rdata,
  output logic                 if_err,
  input  logic                 ls_req,
  input  logic                 ls_we,
  input  logic [WORD_SIZE-1:0] ls_addr,
  input  logic [WORD_SIZE-1:0] ls_wdata,
  input  logic [2:0]           ls_funct3,
  output logic                 ls_gnt,
  output logic                 ls_rvalid,
  output logic [WORD_SIZE-1:0] ls_rdata,
  output logic                 ls_err,
  output logic                 mem_write_en,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_write_data,
  output logic [1:0]           mem_ctrl,
  input  logic [WORD_SIZE-1:0] mem_data
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  state_t                 r_state, w_state_next;
  logic [CNT_W-1:0]       r_starve_cnt, w_starve_cnt_next;
  logic                   r_if_err, r_ls_err;
  logic [WORD_SIZE-1:0]   r_if_rdata, r_ls_rdata;
  logic                   w_ls_gnt, w_if_gnt;
  logic                   w_f3_ok, w_align_ok, w_ls_legal, w_if_aligned;
  logic [WORD_SIZE-1:0]   w_ext;

  // IF only overrides LS once LS has won STARVE_LIMIT times in a row against it.
  assign w_ls_gnt     = ls_req && !(if_req && (r_starve_cnt == CNT_MAX));
  assign w_if_gnt     = if_req && !w_ls_gnt;
  assign w_if_aligned = (if_addr[1:0] == 2'b00);

  always_comb begin
    w_f3_ok = 1'b0;
    case (ls_funct3)
      LB, LH, LW: w_f3_ok = 1'b1;
      LBU, LHU:   w_f3_ok = !ls_we;
      default:    w_f3_ok = 1'b0;
    endcase
    w_align_ok = 1'b1;
    case (ls_funct3[1:0])
      HALF:    w_align_ok = !ls_addr[0];
      WORD:    w_align_ok = (ls_addr[1:0] == 2'b00);
      default: w_align_ok = 1'b1;
    endcase
    w_ls_legal = w_f3_ok && w_align_ok;
  end

  always_comb begin
    mem_write_en   = 1'b0;
    mem_addr       = '0;
    mem_ctrl       = WORD;
    mem_write_data = ls_wdata;
    if (w_ls_gnt) begin
      mem_write_en = ls_we && w_ls_legal;
      mem_addr     = ls_addr;
      mem_ctrl     = ls_funct3[1:0];
    end else if (w_if_gnt) begin
      mem_addr = if_addr;
    end
  end

  load_extend #(
    .WORD_SIZE(WORD_SIZE)
  ) u_load_extend (
    .i_funct3(ls_funct3),
    .i_raw   (mem_data),
    .o_data  (w_ext)
  );

  always_comb begin
    w_state_next = IDLE;
    if (w_ls_gnt) begin
      w_state_next = LS_RESP;
    end else if (w_if_gnt) begin
      w_state_next = IF_RESP;
    end

    w_starve_cnt_next = r_starve_cnt;
    if (w_if_gnt || !if_req) begin
      w_starve_cnt_next = '0;
    end else if (w_ls_gnt && (r_starve_cnt != CNT_MAX)) begin
      w_starve_cnt_next = r_starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_if_err     <= 1'b0;
      r_if_rdata   <= '0;
      r_ls_err     <= 1'b0;
      r_ls_rdata   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_starve_cnt <= w_starve_cnt_next;
      if (w_if_gnt) begin
        r_if_err   <= !w_if_aligned;
        r_if_rdata <= w_if_aligned ? mem_data : '0;
      end
      if (w_ls_gnt) begin
        r_ls_err   <= !w_ls_legal;
        r_ls_rdata <= (w_ls_legal && !ls_we) ? w_ext : '0;
      end
    end
  end

  assign if_gnt    = w_if_gnt;
  assign ls_gnt    = w_ls_gnt;
  assign if_rvalid = (r_state == IF_RESP);
  assign ls_rvalid = (r_state == LS_RESP);
  assign if_rdata  = r_if_rdata;
  assign if_err    = r_if_err;
  assign ls_rdata  = r_ls_rdata;
  assign ls_err    = r_ls_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-array memory and a per-cycle reference model.
module tb_mem_port_arbiter;

  localparam int unsigned WS = 32;
  localparam int unsigned SL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_init = 1'b1;
  logic          if_req, ls_req, ls_we;
  logic [WS-1:0] if_addr, ls_addr, ls_wdata;
  logic [2:0]    ls_funct3;
  logic          if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err;
  logic [WS-1:0] if_rdata, ls_rdata;
  logic          mem_write_en;
  logic [WS-1:0] mem_addr, mem_write_data, mem_data;
  logic [1:0]    mem_ctrl;

  logic [7:0] dev_mem [1024];
  logic [7:0] mdl_mem [1024];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .WORD_SIZE   (WS),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_gnt        (if_gnt),
    .if_rvalid     (if_rvalid),
    .if_rdata      (if_rdata),
    .if_err        (if_err),
    .ls_req        (ls_req),
    .ls_we         (ls_we),
    .ls_addr       (ls_addr),
    .ls_wdata      (ls_wdata),
    .ls_funct3     (ls_funct3),
    .ls_gnt        (ls_gnt),
    .ls_rvalid     (ls_rvalid),
    .ls_rdata      (ls_rdata),
    .ls_err        (ls_err),
    .mem_write_en  (mem_write_en),
    .mem_addr      (mem_addr),
    .mem_write_data(mem_write_data),
    .mem_ctrl      (mem_ctrl),
    .mem_data      (mem_data)
  );

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
    end
  endfunction

  // Memory device: async, right-justified sized reads; sized little-endian writes.
  always_comb begin
    mem_data = '0;
    for (int b = 0; b < 4; b++) begin
      if (b < (1 << mem_ctrl)) mem_data[8*b +: 8] = dev_mem[10'(mem_addr + 32'(b))];
    end
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) dev_mem[i] <= 8'h00;
      dev_mem[0] <= 8'h03; dev_mem[1] <= 8'hA3; dev_mem[2] <= 8'h44; dev_mem[3] <= 8'h00;
    end else if (mem_write_en) begin
      for (int b = 0; b < 4; b++) begin
        if (b < (1 << mem_ctrl)) dev_mem[10'(mem_addr + 32'(b))] <= mem_write_data[8*b +: 8];
      end
    end
  end

  function automatic logic mdl_legal(logic we, logic [2:0] f3, logic [31:0] a);
    int sz;
    if (we ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    sz = 1 << f3[1:0];
    return (a % sz) == 0;
  endfunction

  function automatic logic [31:0] mdl_load(logic [2:0] f3, logic [31:0] a);
    int sz;
    logic [31:0] v;
    sz = 1 << f3[1:0];
    v = 32'h0;
    for (int b = 0; b < sz; b++) v = v | (32'(mdl_mem[10'(a + 32'(b))]) << (8 * b));
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
    return v;
  endfunction

  // Reference model: grant rule, memory drive and next-cycle responses, checked every cycle.
  logic        e_if_v, e_ls_v, e_if_e, e_ls_e;
  logic [31:0] e_if_d, e_ls_d;
  int          mdl_cnt;

  always @(negedge clk) begin
    logic g_ls, g_if, lg;
    if (rst) begin
      if (mem_init) begin
        for (int i = 0; i < 1024; i++) mdl_mem[i] = 8'h00;
        mdl_mem[0] = 8'h03; mdl_mem[1] = 8'hA3; mdl_mem[2] = 8'h44; mdl_mem[3] = 8'h00;
      end
      chk("rst_if_rvalid", 32'(if_rvalid), 0);
      chk("rst_ls_rvalid", 32'(ls_rvalid), 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_ls_rdata", ls_rdata, 0);
      e_if_v = 1'b0;
      e_ls_v = 1'b0;
      mdl_cnt = 0;
    end else begin
      chk("mdl_if_rvalid", 32'(if_rvalid), 32'(e_if_v));
      chk("mdl_ls_rvalid", 32'(ls_rvalid), 32'(e_ls_v));
      if (e_if_v) begin
        chk("mdl_if_rdata", if_rdata, e_if_d);
        chk("mdl_if_err", 32'(if_err), 32'(e_if_e));
      end
      if (e_ls_v) begin
        chk("mdl_ls_rdata", ls_rdata, e_ls_d);
        chk("mdl_ls_err", 32'(ls_err), 32'(e_ls_e));
      end
      g_ls = ls_req && !(if_req && mdl_cnt == int'(SL));
      g_if = if_req && !g_ls;
      lg   = mdl_legal(ls_we, ls_funct3, ls_addr);
      chk("mdl_ls_gnt", 32'(ls_gnt), 32'(g_ls));
      chk("mdl_if_gnt", 32'(if_gnt), 32'(g_if));
      chk("mdl_mem_we", 32'(mem_write_en), 32'(g_ls && ls_we && lg));
      chk("mdl_mem_addr", mem_addr, g_ls ? ls_addr : (g_if ? if_addr : 32'h0));
      chk("mdl_mem_ctrl", 32'(mem_ctrl), g_ls ? 32'(ls_funct3[1:0]) : 32'd2);
      chk("mdl_mem_wdata", mem_write_data, ls_wdata);
      e_if_v = g_if;
      e_ls_v = g_ls;
      if (g_if) begin
        e_if_e = (if_addr[1:0] != 2'b00);
        e_if_d = e_if_e ? 32'h0 : {mdl_mem[10'(if_addr + 3)], mdl_mem[10'(if_addr + 2)],
                                   mdl_mem[10'(if_addr + 1)], mdl_mem[10'(if_addr)]};
      end
      if (g_ls) begin
        e_ls_e = !lg;
        e_ls_d = (lg && !ls_we) ? mdl_load(ls_funct3, ls_addr) : 32'h0;
        if (lg && ls_we) begin
          for (int b = 0; b < (1 << ls_funct3[1:0]); b++) begin
            mdl_mem[10'(ls_addr + 32'(b))] = ls_wdata[8*b +: 8];
          end
        end
      end
      if (!if_req || g_if) mdl_cnt = 0;
      else if (g_ls && mdl_cnt < int'(SL)) mdl_cnt++;
    end
  end

  task automatic ls_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input logic [31:0] exp_d, input logic exp_e,
                        input logic exp_we, input string name);
    logic got;
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = wd; ls_funct3 = f3;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = ls_gnt;
    end
    chk({name, "_gnt"}, 32'(got), 1);
    chk({name, "_we"}, 32'(mem_write_en), 32'(exp_we));
    @(posedge clk); #1;
    ls_req = 1'b0;
    @(negedge clk);
    chk({name, "_rvalid"}, 32'(ls_rvalid), 1);
    chk({name, "_rdata"}, ls_rdata, exp_d);
    chk({name, "_err"}, 32'(ls_err), 32'(exp_e));
  endtask

  task automatic if_txn(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_e,
                        input string name);
    logic got;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = a;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = if_gnt;
    end
    chk({name, "_gnt"}, 32'(got), 1);
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    chk({name, "_rvalid"}, 32'(if_rvalid), 1);
    chk({name, "_rdata"}, if_rdata, exp_d);
    chk({name, "_err"}, 32'(if_err), 32'(exp_e));
  endtask

  // Both requesters held: LS wins SL times, then IF, repeating, never an idle cycle.
  task automatic run_both(input int n, input string name);
    logic exp_ls;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h4;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100; ls_funct3 = 3'b010;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      exp_ls = (i % 5) != 4;
      chk({name, "_ls_gnt"}, 32'(ls_gnt), 32'(exp_ls));
      chk({name, "_if_gnt"}, 32'(if_gnt), 32'(!exp_ls));
    end
    @(posedge clk); #1;
    if_req = 1'b0; ls_req = 1'b0;
  endtask

  initial begin
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_funct3 = 3'b010;
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    rst = 1'b0;

    if_txn(32'h0, 32'h0044A303, 1'b0, "fetch0");
    ls_txn(1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0, 1'b1, "sw100");
    ls_txn(1'b0, 32'h100, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 1'b0, "lw100");
    ls_txn(1'b0, 32'h103, 32'h0, 3'b000, 32'hFFFFFFDE, 1'b0, 1'b0, "lb103");
    ls_txn(1'b0, 32'h103, 32'h0, 3'b100, 32'h000000DE, 1'b0, 1'b0, "lbu103");
    ls_txn(1'b0, 32'h102, 32'h0, 3'b001, 32'hFFFFDEAD, 1'b0, 1'b0, "lh102");
    ls_txn(1'b0, 32'h102, 32'h0, 3'b101, 32'h0000DEAD, 1'b0, 1'b0, "lhu102");

    run_both(15, "starve");

    ls_txn(1'b0, 32'h102, 32'h0, 3'b010, 32'h0, 1'b1, 1'b0, "lw_mis");
    ls_txn(1'b1, 32'h101, 32'h00001234, 3'b001, 32'h0, 1'b1, 1'b0, "sh_mis");
    ls_txn(1'b1, 32'h100, 32'h00000055, 3'b100, 32'h0, 1'b1, 1'b0, "st_badf3");
    ls_txn(1'b0, 32'h100, 32'h0, 3'b011, 32'h0, 1'b1, 1'b0, "ld_badf3");
    ls_txn(1'b0, 32'h100, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 1'b0, "lw_unchanged");
    ls_txn(1'b1, 32'h102, 32'h0000A5C3, 3'b001, 32'h0, 1'b0, 1'b1, "sh102");
    ls_txn(1'b0, 32'h100, 32'h0, 3'b010, 32'hA5C3BEEF, 1'b0, 1'b0, "lw_after_sh");
    if_txn(32'h6, 32'h0, 1'b1, "fetch_mis");

    // Build up starvation count, then reset with a load response still pending.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h4;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100; ls_funct3 = 3'b010;
    @(negedge clk);
    chk("pre_rst_gnt0", 32'(ls_gnt), 1);
    @(negedge clk);
    chk("pre_rst_gnt1", 32'(ls_gnt), 1);
    #1;
    rst = 1'b1; if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    chk("rst_drop_ls_rvalid", 32'(ls_rvalid), 0);
    @(negedge clk);
    chk("rst_hold_ls_rvalid", 32'(ls_rvalid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ls_rvalid", 32'(ls_rvalid), 0);
    chk("post_rst_if_rvalid", 32'(if_rvalid), 0);

    run_both(10, "after_rst");
    ls_txn(1'b0, 32'h103, 32'h0, 3'b000, 32'hFFFFFFA5, 1'b0, 1'b0, "lb_after_rst");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
